// File: rtl/trap_ctrl.sv
// trap_ctrl: sequences trap entry and return around the PC register.
// Arbitrates masked level-sensitive interrupts against synchronous
// exceptions, saves the resume address (epc) and cause, and issues
// one-cycle PC redirects to the trap vectors and back to epc on eret.
//
// Ports:
//   clk, reset      clock (rising edge), asynchronous active-high reset
//   irq_req         level-sensitive interrupt requests
//   mask_we/wdata   interrupt mask write (1 = enabled)
//   exc/exc_cause   exception pulse and code for the current instruction
//   ia              address of the current instruction
//   pcin            next-PC value from the datapath
//   eret            return-from-trap pulse
//   redirect        PC loads redirect_pc this cycle
//   redirect_pc     redirect target (holds when redirect is low)
//   irq_ack         one-hot acknowledge of the taken interrupt
//   epc             saved resume address
//   cause           {irq, nested, 2'b00, index/code}
//   irq_mask        current interrupt mask
//   in_handler      high while a trap is being serviced
module trap_ctrl #(
  parameter int unsigned N_IRQ   = 4,
  parameter logic [31:0] VEC_EXC = 32'h8000_0004,
  parameter logic [31:0] VEC_IRQ = 32'h8000_0008
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_req,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  input  logic             exc,
  input  logic [3:0]       exc_cause,
  input  logic [31:0]      ia,
  input  logic [31:0]      pcin,
  input  logic             eret,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic [N_IRQ-1:0] irq_ack,
  output logic [31:0]      epc,
  output logic [7:0]       cause,
  output logic [N_IRQ-1:0] irq_mask,
  output logic             in_handler
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    ENTER   = 2'd1,
    HANDLER = 2'd2,
    LEAVE   = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic             redirect_nxt;
  logic [31:0]      redirect_pc_nxt;
  logic [N_IRQ-1:0] irq_ack_nxt;
  logic [31:0]      epc_nxt;
  logic [7:0]       cause_nxt;
  logic [N_IRQ-1:0] irq_mask_nxt;
  logic             in_handler_nxt;

  logic [N_IRQ-1:0] pending;
  logic [3:0]       irq_idx;
  logic             irq_found;

  // Lowest-index priority encoder over the masked requests (old mask).
  always_comb begin
    pending   = irq_req & irq_mask;
    irq_idx   = 4'd0;
    irq_found = |pending;
    for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
      if (pending[i]) irq_idx = 4'(i);
    end
  end

  // State register and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      redirect    <= 1'b0;
      redirect_pc <= 32'h0;
      irq_ack     <= '0;
      epc         <= 32'h0;
      cause       <= 8'h0;
      irq_mask    <= '0;
      in_handler  <= 1'b0;
    end else begin
      state       <= state_nxt;
      redirect    <= redirect_nxt;
      redirect_pc <= redirect_pc_nxt;
      irq_ack     <= irq_ack_nxt;
      epc         <= epc_nxt;
      cause       <= cause_nxt;
      irq_mask    <= irq_mask_nxt;
      in_handler  <= in_handler_nxt;
    end
  end

  // Next state and next register values. Redirect/ack are computed on
  // the transition into ENTER/LEAVE so they are visible during that state.
  always_comb begin
    state_nxt       = state;
    redirect_nxt    = 1'b0;
    redirect_pc_nxt = redirect_pc;
    irq_ack_nxt     = '0;
    epc_nxt         = epc;
    cause_nxt       = cause;
    irq_mask_nxt    = mask_we ? mask_wdata : irq_mask;
    in_handler_nxt  = in_handler;

    unique case (state)
      RUN: begin
        // Exception wins; a coincident interrupt stays pending.
        if (exc) begin
          epc_nxt         = ia;
          cause_nxt       = {4'b0000, exc_cause};
          redirect_nxt    = 1'b1;
          redirect_pc_nxt = VEC_EXC;
          state_nxt       = ENTER;
        end else if (irq_found) begin
          epc_nxt         = pcin;
          cause_nxt       = {4'b1000, irq_idx};
          irq_ack_nxt     = N_IRQ'(1) << irq_idx;
          redirect_nxt    = 1'b1;
          redirect_pc_nxt = VEC_IRQ;
          state_nxt       = ENTER;
        end
      end
      ENTER: begin
        in_handler_nxt = 1'b1;
        state_nxt      = HANDLER;
      end
      HANDLER: begin
        // Nested fault keeps the original epc so eret resumes the first trap.
        if (exc) begin
          cause_nxt       = {4'b0100, exc_cause};
          redirect_nxt    = 1'b1;
          redirect_pc_nxt = VEC_EXC;
          state_nxt       = ENTER;
        end else if (eret) begin
          redirect_nxt    = 1'b1;
          redirect_pc_nxt = epc;
          state_nxt       = LEAVE;
        end
      end
      LEAVE: begin
        in_handler_nxt = 1'b0;
        cause_nxt[6]   = 1'b0;
        state_nxt      = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Sequencer for trap entry and return around the program counter register.
- Collects masked interrupt requests and synchronous exceptions, arbitrates them, and saves the resume address (EPC) and cause.
- Issues one-cycle PC redirects to the exception/interrupt vectors and back to EPC on ERET.
- Sits between the datapath control unit and the PC mux, replacing direct irq/Exception drive of the PC.

Parameters:
- N_IRQ, 4, number of interrupt request lines (1..8).
- VEC_EXC, 32'h8000_0004, exception handler vector.
- VEC_IRQ, 32'h8000_0008, interrupt handler vector.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- irq_req  input  N_IRQ  level-sensitive interrupt requests.
- mask_we  input  1  write strobe for the interrupt mask.
- mask_wdata  input  N_IRQ  new mask value; 1 = enabled.
- exc  input  1  exception pulse, valid for the current instruction.
- exc_cause  input  4  exception code, sampled with exc.
- ia  input  32  address of the current instruction.
- pcin  input  32  next-PC value from the datapath.
- eret  input  1  return-from-trap pulse.
- redirect  output  1  PC must load redirect_pc this cycle.
- redirect_pc  output  32  redirect target.
- irq_ack  output  N_IRQ  one-hot acknowledge of the taken interrupt.
- epc  output  32  saved resume address.
- cause  output  8  bit7 = interrupt, bit6 = nested fault, bits3:0 = irq index or exception code.
- irq_mask  output  N_IRQ  current mask.
- in_handler  output  1  high while a trap is being serviced.

Behaviour:
- Reset (asynchronous): state RUN; redirect, irq_ack, irq_mask, epc, cause, in_handler, redirect_pc all 0.
- States: RUN, ENTER, HANDLER, LEAVE. All outputs are registered.
- pending = irq_req & irq_mask. Lowest set index wins.
- RUN:
  - exc = 1 → epc <= ia; cause <= {2'b00, 2'b00, exc_cause}; go to ENTER with target VEC_EXC.
  - Else pending != 0 → epc <= pcin; cause <= {1'b1, 3'b000, index}; irq_ack <= one-hot(index); go to ENTER with target VEC_IRQ.
  - Exception has priority over interrupt in the same cycle. The interrupt stays pending, because it is level-sensitive.
  - eret in RUN is ignored.
- ENTER (exactly 1 cycle):
  - redirect = 1 and redirect_pc = target; irq_ack is high only in this cycle, for the interrupt case.
  - in_handler <= 1. Next state HANDLER.
  - Trap latency: event sampled at edge N, redirect high during cycle N+1.
- HANDLER:
  - Interrupts are not taken; there is no nesting.
  - exc = 1 → cause[6] <= 1; cause[3:0] <= exc_cause; cause[7] <= 0; epc is NOT overwritten; go to ENTER with target VEC_EXC.
  - eret = 1 → go to LEAVE. exc has priority over a simultaneous eret.
- LEAVE (exactly 1 cycle):
  - redirect = 1, redirect_pc = epc; in_handler <= 0; cause[6] <= 0. Next state RUN.
  - exc and irq inputs are ignored in LEAVE. An interrupt is evaluated at the earliest in the first RUN cycle after LEAVE.
- Mask:
  - mask_we loads irq_mask at the edge, in any state.
  - Arbitration in that same cycle uses the old mask.
- redirect_pc holds its last value when redirect = 0.
- irq_ack is 0 outside ENTER.
- Reset asserted mid-trap: immediate return to the reset values; no redirect is issued. The PC independently loads its reset vector.

Test Plan:
- Reset, then set mask=4'b0110 and raise irq_req=4'b0110 with pcin=32'h8000_0100 → next cycle: redirect=1, redirect_pc=32'h8000_0008, irq_ack=4'b0010, cause=8'h81, epc=32'h8000_0100; in_handler=1 from then on.
- In RUN, pulse exc with exc_cause=4'hC, ia=32'h8000_0040, and irq_req active in the same cycle → redirect to 32'h8000_0004, epc=32'h8000_0040, cause=8'h0C, irq_ack=0. Then eret → redirect_pc=32'h8000_0040. On the first RUN cycle after that, the pending interrupt is taken.
- In HANDLER, pulse exc with exc_cause=4'h3 → redirect to VEC_EXC, cause=8'h43, epc unchanged. Then eret → cause[6]=0 and the redirect goes to the original EPC.
- Hold irq_req=4'b0001 with mask=0; pulse eret in RUN → no redirect and no irq_ack. Then write mask=1 → interrupt taken exactly 2 cycles after the mask_we edge (update edge, then arbitration edge).
- Assert reset asynchronously while in ENTER and while in HANDLER → all outputs return to 0 immediately, without waiting for a clock edge; state is RUN.
